// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS load/store path to the Avalon-MM master.
//   - access size encodings as seen on the core request
//   - memory-unit FSM state type
//   - alignment check, lane-enable and store-data replication helpers
package mips_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size 3 has no meaning on the core side, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] calc_byteenable(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return 4'b0011 << addr_lo;
      default:   return 4'b1111;
    endcase
  endfunction

  // Store data is right-justified on the core side; the bus wants it on
  // every lane so byteenable alone picks the written bytes.
  function automatic logic [31:0] replicate_wdata(input logic [1:0]  size,
                                                  input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of a 32-bit
// little-endian bus word and sign- or zero-extends it to 32 bits.
// Purely combinational.
//   size_i     : access size (byte/half/word)
//   signed_i   : 1 = sign-extend, 0 = zero-extend
//   addr_lo_i  : byte offset within the word
//   rdata_i    : raw bus read data
//   data_o     : right-justified, extended load result
module mips_load_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mips_avalon_mem_unit.sv
// Load/store front-end between the multicycle MIPS core and an Avalon-MM
// master port. One access in flight at a time; all outputs registered.
//   core side : req_valid/req_ready handshake, req_write, req_size,
//               req_signed, req_addr, req_wdata; resp_valid pulse with
//               resp_rdata and resp_error
//   bus side  : address (word aligned), read, write, writedata,
//               byteenable, waitrequest, readdata
// TIMEOUT bounds how long a strobe may sit under waitrequest; 0 disables it.
module mips_avalon_mem_unit
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_error_q, resp_error_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [31:0]         writedata_q, writedata_d;
  logic [3:0]          byteenable_q, byteenable_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                misaligned;
  logic                strobe;
  logic                done;
  logic                timeout_hit;
  logic [CNT_W-1:0]    cnt_inc;
  logic [31:0]         load_data;

  mips_load_align u_load_align (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (readdata),
    .data_o    (load_data)
  );

  // Accept only while req_ready is actually shown to the core.
  assign accept     = (state_q == IDLE) && req_ready_q && req_valid;
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign strobe     = read_q | write_q;
  assign done       = (state_q == BUS) && strobe && !waitrequest;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  // Abort on the edge where the stall count would reach TIMEOUT, so the
  // strobe is visible for exactly TIMEOUT stalled cycles.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == BUS) && strobe &&
                       waitrequest && (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      addr_lo_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misaligned ? RESP : BUS;
      BUS:     if (done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;

    if (accept) begin
      size_d    = req_size;
      signed_d  = req_signed;
      addr_lo_d = req_addr[1:0];
      cnt_d     = '0;
      if (misaligned) begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
      end else begin
        address_d    = {req_addr[ADDR_W-1:2], 2'b00};
        byteenable_d = calc_byteenable(req_size, req_addr[1:0]);
        writedata_d  = replicate_wdata(req_size, req_wdata);
        read_d       = !req_write;
        write_d      = req_write;
      end
    end

    if (state_q == BUS) begin
      if (waitrequest) cnt_d = cnt_inc;
      if (done) begin
        read_d       = 1'b0;
        write_d      = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = read_q ? load_data : 32'd0;
      end else if (timeout_hit) begin
        read_d       = 1'b0;
        write_d      = 1'b0;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_avalon_mem_unit.sv
// Randomized bench for mips_avalon_mem_unit against a transaction-level
// model. A second instance with TIMEOUT = 0 sees the first request under a
// permanently asserted waitrequest and must keep its strobe up to the end.
module tb_mips_avalon_mem_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset, reset0;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        waitrequest, wr0;
  logic [31:0] readdata;

  logic        req_ready, resp_valid, resp_error, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0]  byteenable;

  logic        req_ready0, resp_valid0, resp_error0, read0, write0;
  logic [31:0] resp_rdata0, address0, writedata0;
  logic [3:0]  byteenable0;

  int n_checks = 0;
  int n_fail   = 0;
  int rv0_cnt  = 0;

  always #5 clk = ~clk;

  mips_avalon_mem_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  mips_avalon_mem_unit #(.ADDR_W(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset0),
    .req_valid(req_valid), .req_ready(req_ready0), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .resp_error(resp_error0), .address(address0), .read(read0), .write(write0),
    .waitrequest(wr0), .writedata(writedata0),
    .byteenable(byteenable0), .readdata(readdata)
  );

  always @(posedge clk) if (resp_valid0) rv0_cnt <= rv0_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One core access against an ideal slave that stalls nwait cycles.
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int nwait,
                        input bit hold, output logic [31:0] got_rdata);
    int n, nbytes, cycles;
    bit mis, tmo;
    logic [3:0]  be;
    logic [31:0] wd, v;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata; readdata = ~rdata;
    waitrequest = 1'b0;
    tick();
    if (!hold) req_valid = 1'b0;
    mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
          (sz == 2'd2 && addr[1:0] != 2'b00);
    tmo = 1'b0;
    if (mis) begin
      check("mis_read",  32'(read), 32'd0);
      check("mis_write", 32'(write), 32'd0);
      check("mis_rv",    32'(resp_valid), 32'd1);
      check("mis_err",   32'(resp_error), 32'd1);
      check("mis_rdata", resp_rdata, 32'd0);
    end else begin
      nbytes = 1 << sz;
      be = 4'(((1 << nbytes) - 1) << addr[1:0]);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      tmo = (TO != 0) && (nwait >= TO);
      cycles = tmo ? TO : nwait + 1;
      for (int k = 0; k < cycles; k++) begin
        waitrequest = (k < nwait);
        readdata = (k < nwait) ? ~rdata : rdata;
        check("bus_addr",  address, {addr[31:2], 2'b00});
        check("bus_be",    32'(byteenable), 32'(be));
        check("bus_read",  32'(read), 32'(!w));
        check("bus_write", 32'(write), 32'(w));
        check("bus_rv",    32'(resp_valid), 32'd0);
        check("bus_ready", 32'(req_ready), 32'd0);
        if (w) check("bus_wdata", writedata, wd);
        tick();
      end
      waitrequest = 1'b0;
      if (w || tmo) v = 32'd0;
      else begin
        v = rdata >> (8 * addr[1:0]);
        if (sz == 2'd0) begin
          v = v & 32'hFF;
          if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
          v = v & 32'hFFFF;
          if (sg && v >= 32'd32768) v = v - 32'd65536;
        end
      end
      check("end_read",  32'(read), 32'd0);
      check("end_write", 32'(write), 32'd0);
      check("resp_rv",   32'(resp_valid), 32'd1);
      check("resp_err",  32'(resp_error), 32'(tmo));
      check("resp_rdata", resp_rdata, v);
    end
    check("resp_ready", 32'(req_ready), 32'd0);
    got_rdata = resp_rdata;
    tick();
    check("post_rv",    32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_read",  32'(read), 32'd0);
    check("post_write", 32'(write), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [1:0]  sz;
    int          nw;

    reset = 1'b1; reset0 = 1'b1; wr0 = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; waitrequest = 1'b0; readdata = 32'd0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rv",    32'(resp_valid), 32'd0);
    check("rst_err",   32'(resp_error), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr",  address, 32'd0);
    check("rst_read",  32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_be",    32'(byteenable), 32'd0);
    reset = 1'b0; reset0 = 1'b0;
    tick();
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // Plan vectors, also pinned against literal results.
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, got);
    check("plan_word", got, 32'hDEADBEEF);
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, got);
    check("plan_byte_s", got, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, got);
    check("plan_byte_u", got, 32'h00000080);
    access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80112233, 2, 1'b0, got);
    check("plan_half_s", got, 32'hFFFF8011);
    access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h12345678, 3, 1'b0, got);
    check("plan_half_st", got, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11111111, 0, 1'b0, got);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h11111111, 0, 1'b0, got);
    // Timeout boundary: one short of the limit completes, at the limit aborts.
    access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, TO - 1, 1'b0, got);
    access(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 32'hCAFEF00D, TO, 1'b0, got);
    access(1'b1, 2'd0, 1'b0, 32'h405, 32'hA5, 32'h0, 40, 1'b0, got);
    // req_valid held high through BUS/RESP must not be accepted early.
    access(1'b0, 2'd1, 1'b0, 32'h506, 32'h0, 32'h7F00FE01, 1, 1'b1, got);
    access(1'b0, 2'd0, 1'b1, 32'h501, 32'h0, 32'h7F00FE01, 0, 1'b1, got);
    access(1'b1, 2'd2, 1'b0, 32'h502, 32'h0, 32'h0, 0, 1'b0, got);

    // Reset during a stalled read.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300;
    waitrequest = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_read1", 32'(read), 32'd1);
    tick();
    check("mid_read2", 32'(read), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_rv",   32'(resp_valid), 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    tick();
    check("mid_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_rv", 32'(resp_valid), 32'd0);
      check("mid_no_rd", 32'(read), 32'd0);
      tick();
    end

    for (int t = 0; t < 250; t++) begin
      a  = $urandom();
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      case ($urandom_range(0, 9))
        0:       nw = TO - 1;
        1:       nw = TO + $urandom_range(0, 3);
        default: nw = $urandom_range(0, 3);
      endcase
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             $urandom(), $urandom(), nw,
             (t != 249) && ($urandom_range(0, 4) == 0), got);
    end
    req_valid = 1'b0;

    // The TIMEOUT = 0 instance took the first word load and must still hold it.
    check("tmo0_read", 32'(read0), 32'd1);
    check("tmo0_addr", address0, 32'h100);
    check("tmo0_be",   32'(byteenable0), 32'hF);
    check("tmo0_norv", 32'(rv0_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_avalon_mem_unit.md
Name: mips_avalon_mem_unit

Overview:
- Load/store front-end that sits between the multicycle MIPS core and the Avalon-MM bus master port.
- Accepts one byte, half or word access request at a time from the core.
- Checks alignment, generates `byteenable` and lane-replicated `writedata`, and holds the bus strobe through `waitrequest` stalls.
- Extracts and sign/zero-extends load data, and returns a single-cycle response with an error flag for misalignment or bus timeout.

Parameters:
- ADDR_W, 32, width of core-side and bus-side byte addresses.
- TIMEOUT, 255, max cycles a strobe may be held under `waitrequest` before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- req_signed  in  1  load sign-extends when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualifies `resp_valid`: misaligned or timed out.
- address  out  ADDR_W  word-aligned bus address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- waitrequest  in  1  slave stall.
- writedata  out  32  bus write data.
- byteenable  out  4  lane enables; bit 0 = bits 7:0 (little-endian).
- readdata  in  32  bus read data, valid in the completing cycle.

Behaviour:
- Reset (reset high at a clk edge):
  - state goes to IDLE.
  - `req_ready`, `resp_valid`, `resp_error`, `read`, `write` go to 0.
  - `resp_rdata`, `address`, `writedata`, `byteenable` go to 0.
  - `req_ready` is 1 from the first cycle after reset deasserts.
- All outputs are registered. FSM states are IDLE, BUS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request is captured (cycle N).
  - Misaligned request → RESP with `resp_error` = 1 and no bus strobe. Misaligned means size = 3, half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Otherwise → BUS. At N+1 drive:
    - `address` = {addr[ADDR_W-1:2], 2'b00}
    - `byteenable`: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111
    - `writedata`: byte replicated ×4; half replicated ×2; word as is
    - `read` = !req_write, `write` = req_write
- BUS:
  - `address`, `writedata`, `byteenable` and the strobe are held stable while `waitrequest` = 1.
  - A transfer completes in the first cycle with strobe = 1 and `waitrequest` = 0. On completion, `readdata` is captured, the strobe drops on the next edge, and the FSM goes to RESP.
  - Minimum latency: accept at N, strobe at N+1, `resp_valid` at N+2. Throughput is one access per 3 cycles.
- Timeout:
  - A counter clears on entry to BUS and increments each cycle `waitrequest` = 1.
  - When TIMEOUT ≠ 0 and the count reaches TIMEOUT, the strobe drops and the FSM goes to RESP with `resp_error` = 1 and `resp_rdata` = 0.
- RESP:
  - `resp_valid` = 1 for exactly one cycle, then IDLE.
  - `req_ready` = 0 in BUS and RESP; `req_valid` is ignored there.
- Load extraction:
  - Lane selected by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Extension: sign-extend if `req_signed`, else zero-extend. Word loads pass through unchanged.
- Reset mid-transfer: the strobe drops on the next edge, no response is issued, and the pending request is lost (the core also resets).
- Address wrap: no wrap handling; the address is passed as given.

Decomposition:
- Package mips_bus_pkg:
  - size constants SIZE_BYTE / SIZE_HALF / SIZE_WORD
  - state_t enum (IDLE, BUS, RESP)
  - functions calc_byteenable(size, addr_lo) and is_misaligned(size, addr_lo)
- Sub-module mips_load_align: combinational lane select plus sign/zero extension, reused later by the core's LWL/LWR work.

Test Plan:
- Word load, addr 0x100, `waitrequest` = 0, `readdata` = 0xDEADBEEF → `address` 0x100, `byteenable` 1111, `read` for 1 cycle, `resp_valid` at N+2 with `resp_rdata` 0xDEADBEEF, `resp_error` 0.
- Byte load, addr 0x103, `readdata` = 0x80112233:
  - signed → `byteenable` 1000, `resp_rdata` 0xFFFFFF80
  - unsigned → `resp_rdata` 0x00000080
  - half signed at 0x102 → 0xFFFF8011
- Half store, addr 0x202, `req_wdata` 0x0000ABCD, `waitrequest` high 3 cycles → `address` 0x200, `byteenable` 1100, `writedata` 0xABCDABCD, all stable 4 cycles; `resp_valid` the cycle after completion, `resp_error` 0, `resp_rdata` 0.
- Word load at 0x101 (also size 3) → `read`/`write` never asserted, `resp_valid` and `resp_error` = 1 at N+1, `resp_rdata` 0.
- TIMEOUT = 8, `waitrequest` stuck at 1 → strobe held exactly 8 cycles then drops, `resp_error` 1, `resp_rdata` 0; with TIMEOUT = 0 the strobe is held indefinitely.
- Reset asserted during a stalled read → `read` = 0 next cycle, no `resp_valid`, `req_ready` = 1 the cycle after reset deasserts; a back-to-back `req_valid` during RESP is not accepted until IDLE.
